// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - byte-addressed data-memory responder with word-crossing load/store support
module dmem_resp #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        rw,
    input  logic [3:0]        sel,
    input  logic [31:0]       mem_data,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              stall_req
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, RD1, WR1, DONE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         off_q;
    logic [2:0]         size_q;
    logic               sgn_q;
    logic [31:0]        data_q;
    logic [31:0]        lo_q;
    logic [31:0]        rdata_q;
    logic               rvalid_q;

    logic [31:0]        ram [DEPTH_WORDS];

    logic               req_ld;
    logic               req_st;
    logic [2:0]         req_size;
    logic               req_sgn;
    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         req_off;
    logic               req_cross;
    logic [IDX_W-1:0]   idx_nx;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_word;

    logic [31:0]        src_data;
    logic [1:0]         src_off;
    logic [2:0]         src_size;
    logic [3:0]         src_mask;
    logic [63:0]        wr_wide;
    logic [7:0]         wr_be8;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [31:0]        wr_word;
    logic [3:0]         wr_be;

    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [2:0] size, input logic sgn);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (size)
            3'd1:    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            3'd2:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: return sh[31:0];
        endcase
    endfunction

    // Request decode; unsupported sel codes leave both req_ld and req_st low.
    always_comb begin
        req_ld   = 1'b0;
        req_st   = 1'b0;
        req_size = 3'd4;
        req_sgn  = 1'b0;
        if (rw == 2'b01) begin
            case (sel)
                4'b0001: begin req_st = 1'b1; req_size = 3'd1; end
                4'b0011: begin req_st = 1'b1; req_size = 3'd2; end
                4'b1111: begin req_st = 1'b1; req_size = 3'd4; end
                default: ;
            endcase
        end else if (rw == 2'b10) begin
            case (sel)
                4'b1000: begin req_ld = 1'b1; req_size = 3'd1; req_sgn = 1'b1; end
                4'b1100: begin req_ld = 1'b1; req_size = 3'd2; req_sgn = 1'b1; end
                4'b1111: begin req_ld = 1'b1; req_size = 3'd4; end
                4'b0011: begin req_ld = 1'b1; req_size = 3'd1; end
                4'b0001: begin req_ld = 1'b1; req_size = 3'd2; end
                default: ;
            endcase
        end
    end

    assign req_idx   = mem_addr[IDX_W+1:2];
    assign req_off   = mem_addr[1:0];
    assign req_cross = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    assign idx_nx    = idx_q + 1'b1;

    assign rd_idx  = (state_q == RD1) ? idx_nx : req_idx;
    assign rd_word = ram[rd_idx];

    // Store lanes: the low half of the shifted word goes to word A, the high half to A+1.
    always_comb begin
        src_data = (state_q == WR1) ? data_q : mem_data;
        src_off  = (state_q == WR1) ? off_q  : req_off;
        src_size = (state_q == WR1) ? size_q : req_size;
        case (src_size)
            3'd1:    src_mask = 4'b0001;
            3'd2:    src_mask = 4'b0011;
            default: src_mask = 4'b1111;
        endcase
        wr_wide = {32'b0, src_data} << {src_off, 3'b000};
        wr_be8  = {4'b0, src_mask} << src_off;
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_word = wr_wide[31:0];
        wr_be   = wr_be8[3:0];
        if (!rst && state_q == IDLE && req_st) begin
            wr_en = 1'b1;
        end else if (!rst && state_q == WR1) begin
            wr_en   = 1'b1;
            wr_idx  = idx_nx;
            wr_word = wr_wide[63:32];
            wr_be   = wr_be8[7:4];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) ram[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            off_q    <= 2'b00;
            size_q   <= 3'd0;
            sgn_q    <= 1'b0;
            data_q   <= 32'b0;
            lo_q     <= 32'b0;
            rdata_q  <= 32'b0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ld || req_st) begin
                        idx_q  <= req_idx;
                        off_q  <= req_off;
                        size_q <= req_size;
                        sgn_q  <= req_sgn;
                        data_q <= mem_data;
                        if (req_ld) begin
                            if (req_cross) begin
                                lo_q    <= rd_word;
                                state_q <= RD1;
                            end else begin
                                rdata_q  <= extract({32'b0, rd_word}, req_off, req_size, req_sgn);
                                rvalid_q <= 1'b1;
                                state_q  <= DONE;
                            end
                        end else begin
                            state_q <= req_cross ? WR1 : DONE;
                        end
                    end
                end
                RD1: begin
                    rdata_q  <= extract({rd_word, lo_q}, off_q, size_q, sgn_q);
                    rvalid_q <= 1'b1;
                    state_q  <= DONE;
                end
                WR1:     state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_req = !rst && (((state_q == IDLE) && (req_ld || req_st)) ||
                                (state_q == RD1) || (state_q == WR1));
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
endmodule
